// File: rtl/nibble_packer.sv
// Packs NIBBLES consecutive WIDTH-bit nibbles into one word, nibble k in slot k,
// and holds the word for the consumer under a valid/ready handshake.
module nibble_packer #(
  parameter int NIBBLES = 8,
  parameter int WIDTH   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           nib_in,
  input  logic                       nib_valid,
  output logic                       nib_ready,
  output logic [NIBBLES*WIDTH-1:0]   word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(NIBBLES):0]   count
);

  localparam int IDXW = $clog2(NIBBLES);
  localparam int CW   = $clog2(NIBBLES) + 1;

  typedef enum logic {COLLECT, FULL} state_t;

  state_t                     state_q, state_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic [CW-1:0]              count_q, count_d;
  logic [NIBBLES*WIDTH-1:0]   word_q, word_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      count_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

  // clear takes priority over accept and handoff in the same cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    word_d  = word_q;
    if (clear) begin
      state_d = COLLECT;
      idx_d   = '0;
      count_d = '0;
      word_d  = '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (nib_valid) begin
            word_d[idx_q*WIDTH +: WIDTH] = nib_in;
            count_d = count_q + 1'b1;
            if (idx_q == IDXW'(NIBBLES - 1)) begin
              idx_d   = '0;
              state_d = FULL;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        FULL: begin
          if (word_ready) begin
            state_d = COLLECT;
            idx_d   = '0;
            count_d = '0;
            word_d  = '0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  assign nib_ready  = (state_q == COLLECT);
  assign word_valid = (state_q == FULL);
  assign word_out   = word_q;
  assign count      = count_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer: expected words are queued by the stimulus and
// checked by monitors whenever a new word is presented.
module tb_nibble_packer;

  logic        clock = 1'b0;
  logic        reset, clear, nib_valid, word_ready;
  logic [3:0]  nib_in;
  logic        nib_ready, word_valid;
  logic [31:0] word_out;
  logic [3:0]  count;

  logic        clear2, nib_valid2, word_ready2;
  logic [7:0]  nib_in2;
  logic        nib_ready2, word_valid2;
  logic [15:0] word_out2;
  logic [1:0]  count2;

  int n_checks = 0;
  int n_fail   = 0;
  int handoffs = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp2_q[$];

  always #5 clock = ~clock;

  nibble_packer dut (
    .clock(clock), .reset(reset), .clear(clear),
    .nib_in(nib_in), .nib_valid(nib_valid), .nib_ready(nib_ready),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .count(count)
  );

  nibble_packer #(.NIBBLES(2), .WIDTH(8)) dut2 (
    .clock(clock), .reset(reset), .clear(clear2),
    .nib_in(nib_in2), .nib_valid(nib_valid2), .nib_ready(nib_ready2),
    .word_out(word_out2), .word_valid(word_valid2), .word_ready(word_ready2),
    .count(count2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] v);
    nib_in = v; nib_valid = 1'b1;
    tick();
    nib_valid = 1'b0;
  endtask

  // Scoreboard monitor for the default instance
  logic prev_valid = 1'b0;
  always @(negedge clock) begin
    if (word_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {32'd0, word_out}, 64'hDEAD);
      end else begin
        chk("sb_word", {32'd0, word_out}, {32'd0, exp_q.pop_front()});
        chk("sb_count_full", {60'd0, count}, 64'd8);
      end
    end
    if (word_valid === 1'b1 && word_ready === 1'b1 && reset === 1'b0 && clear === 1'b0)
      handoffs++;
    prev_valid = word_valid;
  end

  logic prev_valid2 = 1'b0;
  always @(negedge clock) begin
    if (word_valid2 === 1'b1 && prev_valid2 !== 1'b1) begin
      if (exp2_q.size() == 0) begin
        chk("unexpected_word2", {48'd0, word_out2}, 64'hDEAD);
      end else begin
        chk("sb2_word", {48'd0, word_out2}, {48'd0, exp2_q.pop_front()});
        chk("sb2_count_full", {62'd0, count2}, 64'd2);
      end
    end
    prev_valid2 = word_valid2;
  end

  initial begin
    logic [3:0] fresh [8];
    fresh = '{4'hC, 4'h0, 4'hF, 4'hF, 4'hE, 4'hE, 4'h1, 4'h5};
    reset = 1'b1; clear = 1'b0; nib_valid = 1'b0; nib_in = '0; word_ready = 1'b0;
    clear2 = 1'b0; nib_valid2 = 1'b0; nib_in2 = '0; word_ready2 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_nib_ready", {63'd0, nib_ready}, 64'd1);
    chk("rst_word_valid", {63'd0, word_valid}, 64'd0);
    chk("rst_count", {60'd0, count}, 64'd0);
    chk("rst_word_out", {32'd0, word_out}, 64'd0);

    // Two-slot instance: 0x34 then 0x12
    nib_in2 = 8'h34; nib_valid2 = 1'b1;
    tick();
    chk("p2_count1", {62'd0, count2}, 64'd1);
    chk("p2_valid_early", {63'd0, word_valid2}, 64'd0);
    nib_in2 = 8'h12; exp2_q.push_back(16'h1234);
    tick();
    nib_valid2 = 1'b0;
    chk("p2_valid", {63'd0, word_valid2}, 64'd1);
    chk("p2_word", {48'd0, word_out2}, 64'h1234);
    chk("p2_nib_ready", {63'd0, nib_ready2}, 64'd0);

    // Back-to-back 1..8, consumer stalled
    for (int i = 0; i < 8; i++) begin
      nib_in = 4'(i + 1); nib_valid = 1'b1;
      if (i == 7) exp_q.push_back(32'h87654321);
      tick();
      chk("b2b_count", {60'd0, count}, 64'(i + 1));
      if (i < 7) chk("b2b_nib_ready", {63'd0, nib_ready}, 64'd1);
    end
    chk("full_nib_ready", {63'd0, nib_ready}, 64'd0);
    chk("full_word_valid", {63'd0, word_valid}, 64'd1);
    nib_in = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_word", {32'd0, word_out}, 64'h87654321);
      chk("hold_count", {60'd0, count}, 64'd8);
    end
    nib_valid = 1'b0;

    // Handoff pulse, then second word
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("ho_word_valid", {63'd0, word_valid}, 64'd0);
    chk("ho_nib_ready", {63'd0, nib_ready}, 64'd1);
    chk("ho_count", {60'd0, count}, 64'd0);
    chk("ho_word_out", {32'd0, word_out}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(32'h3456789A);
      send(4'(4'hA - i));
    end
    chk("w2_word", {32'd0, word_out}, 64'h3456789A);
    word_ready = 1'b1;
    tick();

    // Gapped input with consumer always ready
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(32'h89ABCDEF);
      send(4'(4'hF - i));
      if (i < 7) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          chk("gap_count", {60'd0, count}, 64'(i + 1));
        end
      end
    end
    chk("gap_word_valid", {63'd0, word_valid}, 64'd1);
    chk("gap_word", {32'd0, word_out}, 64'h89ABCDEF);
    tick();
    chk("gap_one_cycle", {63'd0, word_valid}, 64'd0);
    chk("gap_nib_ready", {63'd0, nib_ready}, 64'd1);
    word_ready = 1'b0;

    // Clear with a simultaneous 6th nibble
    for (int i = 0; i < 5; i++) send(4'(i + 1));
    chk("pre_clear_count", {60'd0, count}, 64'd5);
    clear = 1'b1; nib_in = 4'h9; nib_valid = 1'b1;
    tick();
    clear = 1'b0; nib_valid = 1'b0;
    chk("clr_count", {60'd0, count}, 64'd0);
    chk("clr_word_out", {32'd0, word_out}, 64'd0);
    chk("clr_nib_ready", {63'd0, nib_ready}, 64'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back(32'h51EEFF0C);
      send(fresh[i]);
    end
    chk("fresh_word", {32'd0, word_out}, 64'h51EEFF0C);

    // Reset beats clear and handoff while FULL
    reset = 1'b1; clear = 1'b1; word_ready = 1'b1;
    tick();
    reset = 1'b0; clear = 1'b0; word_ready = 1'b0;
    chk("rf_nib_ready", {63'd0, nib_ready}, 64'd1);
    chk("rf_word_valid", {63'd0, word_valid}, 64'd0);
    chk("rf_count", {60'd0, count}, 64'd0);
    chk("rf_word_out", {32'd0, word_out}, 64'd0);
    tick(); tick();

    chk("handoff_total", 64'(handoffs), 64'd3);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("sb2_drained", 64'(exp2_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
